// File: rtl/alu_pkg.sv
// Shared ALU constants: state encoding for the multi-cycle units
// and the default datapath width used across the ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder; the serial adder reuses a
// single instance of this cell for every bit position.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock,
// with a start/busy/done handshake and registered sum/cout/overflow.
module serial_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fa_sum, fa_cout;
    logic             accept;
    logic [WIDTH-1:0] sum_shift;

    full_adder u_fa (
        .A   (a_sr_q[0]),
        .B   (b_sr_q[0]),
        .Cin (carry_q),
        .Sum (fa_sum),
        .Cout(fa_cout)
    );

    assign sum_shift = {fa_sum, sum_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        accept   = 1'b0;

        unique case (state_q)
            S_IDLE: accept = start;
            S_RUN: begin
                sum_sr_d = sum_shift;
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    sum_d   = sum_shift;
                    cout_d  = fa_cout;
                    // carry_q is the carry into the MSB on its bit cycle
                    ovf_d   = carry_q ^ fa_cout;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                accept  = start;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d  = S_RUN;
            a_sr_d   = a;
            b_sr_d   = b;
            carry_d  = cin;
            cnt_d    = '0;
            sum_sr_d = '0;
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
